// File: rtl/l2_lookup_pipe_pkg.sv
// Shared L2 types for the lookup stage and the fill path.
// Geometry constants mirror the local memory configuration.
package l2_lookup_pipe_pkg;

  localparam int L2_NUM_PORTS      = 8;
  localparam int L2_WAY_BITS       = 3;
  localparam int L2_SETS           = 16;
  localparam int L2_SET_BITS       = 4;
  localparam int L2_TAG_BITS       = 8;
  localparam int BITS_PER_LINE     = 128;
  localparam int WORDS_PER_LINE    = 1;
  localparam int HPROT_WIDTH       = 2;
  localparam int STABLE_STATE_BITS = 3;
  localparam int L2_ID_BITS        = 4;

  typedef logic [STABLE_STATE_BITS-1:0] state_t;
  typedef logic [L2_SET_BITS-1:0]       l2_set_t;
  typedef logic [L2_TAG_BITS-1:0]       l2_tag_t;
  typedef logic [L2_WAY_BITS-1:0]       l2_way_t;
  typedef logic [BITS_PER_LINE-1:0]     line_t;
  typedef logic [HPROT_WIDTH-1:0]       hprot_t;
  typedef logic [L2_ID_BITS-1:0]        l2_id_t;

  localparam state_t INVALID = '0;

  typedef struct packed {
    logic    hit;
    l2_way_t way;
    logic    empty;
    l2_set_t set;
    l2_tag_t tag;
    l2_id_t  id;
    line_t   line;
    hprot_t  hprot;
    state_t  state;
  } l2_lookup_rsp_t;

  typedef enum logic {
    LK_INIT,
    LK_RUN
  } lookup_fsm_t;

endpackage

// File: rtl/l2_way_select.sv
// Per-set way resolution: lowest hit, else lowest INVALID, else victim.
// Purely combinational so the fill path can share it.
module l2_way_select
  import l2_lookup_pipe_pkg::*;
#(
  parameter int NUM_WAYS = L2_NUM_PORTS
) (
  input  l2_tag_t [NUM_WAYS-1:0] tags,
  input  state_t  [NUM_WAYS-1:0] states,
  input  l2_tag_t                tag,
  input  l2_way_t                evict_way,
  output logic                   hit,
  output l2_way_t                way,
  output logic                   empty,
  output logic                   multi_hit
);

  logic    has_inv;
  l2_way_t hit_way;
  l2_way_t inv_way;

  always_comb begin
    hit       = 1'b0;
    multi_hit = 1'b0;
    has_inv   = 1'b0;
    hit_way   = '0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (states[w] != INVALID && tags[w] == tag) begin
        if (hit) begin
          multi_hit = 1'b1;
        end else begin
          hit     = 1'b1;
          hit_way = l2_way_t'(w);
        end
      end
      if (states[w] == INVALID && !has_inv) begin
        has_inv = 1'b1;
        inv_way = l2_way_t'(w);
      end
    end
  end

  assign way   = hit ? hit_way :
                 (has_inv ? inv_way : evict_way);
  assign empty = !hit && has_inv;

endmodule

// File: rtl/l2_lookup_pipe.sv
// L2 lookup stage: owns lmem after reset for the state sweep, then
// issues set reads and resolves hit/victim into a registered response.
module l2_lookup_pipe
  import l2_lookup_pipe_pkg::*;
#(
  parameter int NUM_WAYS = L2_NUM_PORTS,
  parameter int NUM_SETS = L2_SETS,
  parameter int ID_BITS  = L2_ID_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  l2_set_t                 req_set,
  input  l2_tag_t                 req_tag,
  input  logic [ID_BITS-1:0]      req_id,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_hit,
  output l2_way_t                 rsp_way,
  output logic                    rsp_empty,
  output l2_set_t                 rsp_set,
  output l2_tag_t                 rsp_tag,
  output logic [ID_BITS-1:0]      rsp_id,
  output line_t                   rsp_line,
  output hprot_t                  rsp_hprot,
  output state_t                  rsp_state,
  input  logic                    ext_wr_req,
  input  l2_set_t                 ext_set,
  output logic                    lookup_idle,
  output logic                    init_done,
  output logic                    multi_hit_err,
  output logic                    lmem_rd_en,
  output logic                    lmem_wr_rst,
  output logic                    lmem_wr_en_state,
  output l2_set_t                 lmem_set_in,
  output state_t [WORDS_PER_LINE-1:0] lmem_wr_data_state,
  input  line_t   [NUM_WAYS-1:0]  lmem_rd_data_line,
  input  l2_tag_t [NUM_WAYS-1:0]  lmem_rd_data_tag,
  input  hprot_t  [NUM_WAYS-1:0]  lmem_rd_data_hprot,
  input  state_t  [NUM_WAYS-1:0][WORDS_PER_LINE-1:0] lmem_rd_data_state,
  input  l2_way_t                 lmem_rd_data_evict_way
);

  localparam l2_set_t LAST_SET = l2_set_t'(NUM_SETS - 1);

  lookup_fsm_t fsm;
  lookup_fsm_t fsm_nxt;
  l2_set_t     sweep_cnt;
  logic        sweep_last;

  logic               s1_valid;
  l2_set_t            s1_set;
  l2_tag_t            s1_tag;
  logic [ID_BITS-1:0] s1_id;

  l2_lookup_rsp_t rsp_q;
  l2_lookup_rsp_t rsp_d;

  logic run;
  logic s2_free;
  logic stall;
  logic accept;
  logic s1_adv;

  logic    sel_hit;
  logic    sel_empty;
  logic    sel_multi;
  l2_way_t sel_way;

  state_t [NUM_WAYS-1:0] way_state;

  assign sweep_last = (sweep_cnt == LAST_SET);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= LK_INIT;
      sweep_cnt <= '0;
    end else begin
      fsm <= fsm_nxt;
      if (fsm == LK_INIT && !sweep_last)
        sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  always_comb begin
    fsm_nxt          = fsm;
    lmem_wr_rst      = 1'b0;
    lmem_wr_en_state = 1'b0;
    init_done        = 1'b0;
    unique case (fsm)
      LK_INIT: begin
        lmem_wr_rst      = 1'b1;
        lmem_wr_en_state = 1'b1;
        if (sweep_last)
          fsm_nxt = LK_RUN;
      end
      LK_RUN: begin
        init_done = 1'b1;
      end
    endcase
  end

  assign lmem_wr_data_state = {WORDS_PER_LINE{INVALID}};

  assign run       = (fsm == LK_RUN);
  assign s2_free   = !rsp_valid || rsp_ready;
  assign stall     = s1_valid && !s2_free;
  assign s1_adv    = !s1_valid || s2_free;
  assign req_ready = run && !ext_wr_req && s1_adv;
  assign accept    = req_valid && req_ready;

  assign lmem_rd_en  = accept;
  assign lookup_idle = !s1_valid && !rsp_valid;

  // Holding the set during a stall keeps SRAM outputs and evict_way valid.
  always_comb begin
    lmem_set_in = req_set;
    priority case (1'b1)
      !run:       lmem_set_in = sweep_cnt;
      stall:      lmem_set_in = s1_set;
      ext_wr_req: lmem_set_in = ext_set;
      default:    lmem_set_in = req_set;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      s1_valid <= 1'b0;
    else if (s1_adv)
      s1_valid <= accept;
    if (accept) begin
      s1_set <= req_set;
      s1_tag <= req_tag;
      s1_id  <= req_id;
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++)
      way_state[w] = lmem_rd_data_state[w][0];
  end

  l2_way_select #(
    .NUM_WAYS (NUM_WAYS)
  ) u_way_select (
    .tags      (lmem_rd_data_tag),
    .states    (way_state),
    .tag       (s1_tag),
    .evict_way (lmem_rd_data_evict_way),
    .hit       (sel_hit),
    .way       (sel_way),
    .empty     (sel_empty),
    .multi_hit (sel_multi)
  );

  always_comb begin
    rsp_d.hit   = sel_hit;
    rsp_d.way   = sel_way;
    rsp_d.empty = sel_empty;
    rsp_d.set   = s1_set;
    rsp_d.tag   = s1_tag;
    rsp_d.id    = s1_id;
    rsp_d.line  = lmem_rd_data_line[sel_way];
    rsp_d.hprot = lmem_rd_data_hprot[sel_way];
    rsp_d.state = way_state[sel_way];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid     <= 1'b0;
      multi_hit_err <= 1'b0;
    end else begin
      if (s2_free)
        rsp_valid <= s1_valid;
      if (s1_valid && sel_multi)
        multi_hit_err <= 1'b1;
    end
    if (s2_free && s1_valid)
      rsp_q <= rsp_d;
  end

  assign rsp_hit   = rsp_q.hit;
  assign rsp_way   = rsp_q.way;
  assign rsp_empty = rsp_q.empty;
  assign rsp_set   = rsp_q.set;
  assign rsp_tag   = rsp_q.tag;
  assign rsp_id    = rsp_q.id;
  assign rsp_line  = rsp_q.line;
  assign rsp_hprot = rsp_q.hprot;
  assign rsp_state = rsp_q.state;

endmodule

// File: tb/tb_l2_lookup_pipe.sv
// Directed bench for l2_lookup_pipe with a behavioural lmem model
// and an in-order response scoreboard.
module tb_l2_lookup_pipe;
  import l2_lookup_pipe_pkg::*;

  localparam int NSETS = L2_SETS;
  localparam int NWAYS = L2_NUM_PORTS;
  localparam state_t ST_V = 3'd3;
  localparam line_t LDEAD = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready;
  l2_set_t req_set;
  l2_tag_t req_tag;
  l2_id_t req_id;
  logic rsp_valid, rsp_ready, rsp_hit, rsp_empty;
  l2_way_t rsp_way;
  l2_set_t rsp_set;
  l2_tag_t rsp_tag;
  l2_id_t rsp_id;
  line_t rsp_line;
  hprot_t rsp_hprot;
  state_t rsp_state;
  logic ext_wr_req;
  l2_set_t ext_set;
  logic lookup_idle, init_done, multi_hit_err;
  logic lmem_rd_en, lmem_wr_rst, lmem_wr_en_state;
  l2_set_t lmem_set_in;
  state_t [WORDS_PER_LINE-1:0] lmem_wr_data_state;
  line_t [NWAYS-1:0] rd_line;
  l2_tag_t [NWAYS-1:0] rd_tag;
  hprot_t [NWAYS-1:0] rd_hprot;
  state_t [NWAYS-1:0][WORDS_PER_LINE-1:0] rd_state;
  l2_way_t rd_evict;

  int checks = 0;
  int failures = 0;
  l2_lookup_rsp_t exp_q[$];
  l2_lookup_rsp_t mon_obs, mon_exp, snap, cur;

  always #5 clk = ~clk;

  l2_lookup_pipe dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_tag(req_tag), .req_id(req_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_empty(rsp_empty),
    .rsp_set(rsp_set), .rsp_tag(rsp_tag), .rsp_id(rsp_id),
    .rsp_line(rsp_line), .rsp_hprot(rsp_hprot), .rsp_state(rsp_state),
    .ext_wr_req(ext_wr_req), .ext_set(ext_set),
    .lookup_idle(lookup_idle), .init_done(init_done),
    .multi_hit_err(multi_hit_err),
    .lmem_rd_en(lmem_rd_en), .lmem_wr_rst(lmem_wr_rst),
    .lmem_wr_en_state(lmem_wr_en_state), .lmem_set_in(lmem_set_in),
    .lmem_wr_data_state(lmem_wr_data_state),
    .lmem_rd_data_line(rd_line), .lmem_rd_data_tag(rd_tag),
    .lmem_rd_data_hprot(rd_hprot), .lmem_rd_data_state(rd_state),
    .lmem_rd_data_evict_way(rd_evict)
  );

  // Local memory model: 1-cycle registered read, sweep and backdoor writes.
  l2_tag_t mtag [NSETS][NWAYS];
  state_t  mst  [NSETS][NWAYS];
  line_t   mln  [NSETS][NWAYS];
  hprot_t  mhp  [NSETS][NWAYS];
  l2_way_t mev  [NSETS];
  logic bd_en = 1'b0, bd_ev_en = 1'b0;
  l2_set_t bd_set;
  l2_way_t bd_way, bd_ev;
  l2_tag_t bd_tag;
  state_t bd_st;
  line_t bd_ln;
  hprot_t bd_hp;

  always @(posedge clk) begin
    if (lmem_wr_rst && lmem_wr_en_state)
      for (int w = 0; w < NWAYS; w++)
        mst[lmem_set_in][w] <= lmem_wr_data_state[0];
    if (bd_en) begin
      mtag[bd_set][bd_way] <= bd_tag;
      mst[bd_set][bd_way]  <= bd_st;
      mln[bd_set][bd_way]  <= bd_ln;
      mhp[bd_set][bd_way]  <= bd_hp;
    end
    if (bd_ev_en)
      mev[bd_set] <= bd_ev;
    if (lmem_rd_en) begin
      for (int w = 0; w < NWAYS; w++) begin
        rd_tag[w]      <= mtag[lmem_set_in][w];
        rd_state[w][0] <= mst[lmem_set_in][w];
        rd_line[w]     <= mln[lmem_set_in][w];
        rd_hprot[w]    <= mhp[lmem_set_in][w];
      end
      rd_evict <= mev[lmem_set_in];
    end
  end

  task automatic chk(input string name, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic line_t line_pat(input int s, input int w);
    return {4{8'hCC, 8'(s), 8'(w), 8'h5A}};
  endfunction

  function automatic l2_lookup_rsp_t mk(
    input logic h, input int w, input logic e, input int s,
    input l2_tag_t t, input int id, input line_t ln,
    input int hp, input state_t st);
    l2_lookup_rsp_t r;
    r.hit = h; r.way = l2_way_t'(w); r.empty = e;
    r.set = l2_set_t'(s); r.tag = t; r.id = l2_id_t'(id);
    r.line = ln; r.hprot = hprot_t'(hp); r.state = st;
    return r;
  endfunction

  function automatic l2_lookup_rsp_t observe();
    l2_lookup_rsp_t r;
    r.hit = rsp_hit; r.way = rsp_way; r.empty = rsp_empty;
    r.set = rsp_set; r.tag = rsp_tag; r.id = rsp_id;
    r.line = rsp_line; r.hprot = rsp_hprot; r.state = rsp_state;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      mon_obs = observe();
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL rsp_unexpected observed=%0h expected=none", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rsp", 256'(mon_obs), 256'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int s, input int w, input l2_tag_t t,
                      input state_t st, input line_t ln, input int hp);
    bd_en = 1'b1; bd_set = l2_set_t'(s); bd_way = l2_way_t'(w);
    bd_tag = t; bd_st = st; bd_ln = ln; bd_hp = hprot_t'(hp);
    tick();
    bd_en = 1'b0;
  endtask

  task automatic poke_ev(input int s, input int e);
    bd_ev_en = 1'b1; bd_set = l2_set_t'(s); bd_ev = l2_way_t'(e);
    tick();
    bd_ev_en = 1'b0;
  endtask

  task automatic fill_set(input int s, input int tbase, input state_t st);
    for (int w = 0; w < NWAYS; w++)
      poke(s, w, l2_tag_t'(tbase + w), st, line_pat(s, w), w % 4);
  endtask

  task automatic drive(input int s, input l2_tag_t t, input int id,
                       input l2_lookup_rsp_t e);
    exp_q.push_back(e);
    req_valid = 1'b1;
    req_set = l2_set_t'(s);
    req_tag = t;
    req_id = l2_id_t'(id);
  endtask

  task automatic wait_accept(input string name, input int max_wait);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 256'(n <= max_wait), 256'(1));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 256'(exp_q.size()), 256'(0));
    tick();
  endtask

  task automatic check_sweep();
    int n = 0;
    @(negedge clk);
    while (lmem_wr_rst && n < NSETS + 4) begin
      chk("sweep_set", 256'(lmem_set_in), 256'(n));
      n++;
      @(negedge clk);
    end
    chk("sweep_len", 256'(n), 256'(NSETS));
    chk("init_done", 256'(init_done), 256'(1));
    chk("ready_idle", 256'(req_ready), 256'(1));
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_set = '0; req_tag = '0;
    req_id = '0; rsp_ready = 1'b1; ext_wr_req = 1'b0; ext_set = '0;
    tick();
    @(negedge clk);
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst_req_ready", 256'(req_ready), 256'(0));
    chk("rst_init_done", 256'(init_done), 256'(0));
    chk("rst_mhe", 256'(multi_hit_err), 256'(0));
    tick();
    rst = 1'b0;
    check_sweep();

    fill_set(5, 8'h10, INVALID);
    poke_ev(5, 6);
    fill_set(6, 8'h40, ST_V);
    poke_ev(6, 3);
    fill_set(7, 8'h50, INVALID);
    for (int w = 0; w < 3; w++)
      poke(7, w, l2_tag_t'(8'h50 + w), ST_V, line_pat(7, w), w % 4);
    poke(7, 5, 8'h77, INVALID, line_pat(7, 5), 1);
    poke_ev(7, 6);

    // cold miss with latency check
    drive(5, 8'h3A, 1, mk(0, 0, 1, 5, 8'h3A, 1, line_pat(5, 0), 0, INVALID));
    wait_accept("cold_acc", 0);
    @(negedge clk);
    chk("lat_t1", 256'(rsp_valid), 256'(0));
    @(negedge clk);
    chk("lat_t2", 256'(rsp_valid), 256'(1));
    tick();

    poke(5, 2, 8'h3A, ST_V, LDEAD, 2);
    drive(5, 8'h3A, 2, mk(1, 2, 0, 5, 8'h3A, 2, LDEAD, 2, ST_V));
    wait_accept("hit_acc", 0);
    drain("hit_drain");

    drive(6, 8'h3A, 3, mk(0, 3, 0, 6, 8'h3A, 3, line_pat(6, 3), 3, ST_V));
    wait_accept("full_acc", 0);
    drain("full_drain");

    drive(7, 8'h77, 4, mk(0, 3, 1, 7, 8'h77, 4, line_pat(7, 3), 3, INVALID));
    wait_accept("inv_acc", 0);
    drain("inv_drain");

    // back-to-back at full throughput
    drive(5, 8'h3A, 5, mk(1, 2, 0, 5, 8'h3A, 5, LDEAD, 2, ST_V));
    wait_accept("b2b_a", 0);
    drive(6, 8'h45, 6, mk(1, 5, 0, 6, 8'h45, 6, line_pat(6, 5), 1, ST_V));
    wait_accept("b2b_b", 0);
    drive(7, 8'h51, 7, mk(1, 1, 0, 7, 8'h51, 7, line_pat(7, 1), 1, ST_V));
    wait_accept("b2b_c", 0);
    drain("b2b_drain");

    // backpressure
    rsp_ready = 1'b0;
    drive(6, 8'h42, 8, mk(1, 2, 0, 6, 8'h42, 8, line_pat(6, 2), 2, ST_V));
    wait_accept("bp_a", 0);
    drive(7, 8'h50, 9, mk(1, 0, 0, 7, 8'h50, 9, line_pat(7, 0), 0, ST_V));
    wait_accept("bp_b", 0);
    drive(5, 8'h3A, 10, mk(1, 2, 0, 5, 8'h3A, 10, LDEAD, 2, ST_V));
    @(negedge clk);
    chk("bp_valid", 256'(rsp_valid), 256'(1));
    chk("bp_ready", 256'(req_ready), 256'(0));
    chk("bp_set", 256'(lmem_set_in), 256'(7));
    chk("bp_rd_en", 256'(lmem_rd_en), 256'(0));
    snap = observe();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cur = observe();
      chk("bp_stable", 256'(cur), 256'(snap));
      chk("bp_ready_hold", 256'(req_ready), 256'(0));
      chk("bp_set_hold", 256'(lmem_set_in), 256'(7));
    end
    tick();
    rsp_ready = 1'b1;
    wait_accept("bp_c", 0);
    drain("bp_drain");

    // external writer while idle
    ext_wr_req = 1'b1; ext_set = 4'd9; req_valid = 1'b1; req_set = 4'd5;
    @(negedge clk);
    chk("ext_idle", 256'(lookup_idle), 256'(1));
    chk("ext_ready", 256'(req_ready), 256'(0));
    chk("ext_set", 256'(lmem_set_in), 256'(9));
    chk("ext_rd_en", 256'(lmem_rd_en), 256'(0));
    tick();
    ext_wr_req = 1'b0; req_valid = 1'b0;

    // multi-hit
    fill_set(8, 8'h60, ST_V);
    poke(8, 1, 8'h66, ST_V, line_pat(8, 1), 1);
    poke(8, 4, 8'h66, ST_V, line_pat(8, 4), 0);
    chk("mhe_pre", 256'(multi_hit_err), 256'(0));
    drive(8, 8'h66, 11, mk(1, 1, 0, 8, 8'h66, 11, line_pat(8, 1), 1, ST_V));
    wait_accept("mh_acc", 0);
    drain("mh_drain");
    chk("mhe_set", 256'(multi_hit_err), 256'(1));
    drive(6, 8'h42, 12, mk(1, 2, 0, 6, 8'h42, 12, line_pat(6, 2), 2, ST_V));
    wait_accept("mh2_acc", 0);
    drain("mh2_drain");
    chk("mhe_sticky", 256'(multi_hit_err), 256'(1));

    // reset with a response pending
    rsp_ready = 1'b0;
    drive(6, 8'h40, 13, mk(1, 0, 0, 6, 8'h40, 13, line_pat(6, 0), 0, ST_V));
    wait_accept("rm_acc", 0);
    @(negedge clk);
    @(negedge clk);
    chk("rm_pending", 256'(rsp_valid), 256'(1));
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rm_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rm_mhe", 256'(multi_hit_err), 256'(0));
    chk("rm_init_done", 256'(init_done), 256'(0));
    chk("rm_wr_rst", 256'(lmem_wr_rst), 256'(1));
    chk("rm_set0", 256'(lmem_set_in), 256'(0));
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    check_sweep();

    // sweep invalidated set 6, so the old tag must not hit
    drive(6, 8'h40, 14, mk(0, 0, 1, 6, 8'h40, 14, line_pat(6, 0), 0, INVALID));
    wait_accept("post_acc", 0);
    drain("post_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
